uart_boot_loader: RTL and testbench
===================================

# uart_boot_loader

Loads the RV32I instruction memory from a UART byte stream before the core runs. It sits directly upstream of the instruction memory: it consumes received bytes from the UART receiver, assembles little-endian 32-bit words and drives the instruction memory write port. It holds the core in reset until a complete, valid image is written.

## Interface

Parameters:

- MAX_WORDS, 512, capacity of instruction memory in words (2 KB).
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.
- HEADER, 8'hA5, frame start byte.

Ports:

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- imem_we  out  1  instruction-memory write enable; a one-cycle pulse.
- imem_addr  out  32  write byte address; always word-aligned.
- imem_wdata  out  32  write data.
- cpu_hold  out  1  holds the core in reset while high.
- done  out  1  image loaded successfully; sticky.
- err  out  1  frame rejected; sticky until the next HEADER.

## Operation

- Frame format: HEADER, LEN_LO, LEN_HI, LEN×4 data bytes, then CSUM (if enabled).
  - LEN is a 16-bit word count.
  - Each word is sent least-significant byte first.
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR. A state advances only on a cycle with rx_valid=1.
- IDLE: a byte equal to HEADER moves to LEN_LO. Any other byte is ignored.
- LEN_LO: latch LEN[7:0] and move to LEN_HI.
- LEN_HI: latch LEN[15:8], then branch on LEN:
  - LEN > MAX_WORDS → ERR.
  - LEN == 0 → CSUM (or DONE if checksum is compiled out).
  - Otherwise → DATA, with word index = 0 and byte index = 0.
- DATA:
  - Each byte is placed into lane byte_idx of the word shift register.
  - byte_idx wraps modulo 4.
  - Every data byte is added into an 8-bit running sum, modulo 256.
  - On the 4th byte of a word, issue a write and increment the word index.
  - After the write for word LEN-1 → CSUM (or DONE).
- CSUM: compare the received byte with the running sum. Equal → DONE; not equal → ERR.
- DONE: done=1 and cpu_hold=0. All further bytes, including HEADER, are ignored. Only rst re-arms the block.
- ERR: err=1 and cpu_hold=1. A HEADER byte clears err, resets the sum and word index, and moves to LEN_LO. Other bytes are ignored.
- Words already written before an error are not rolled back.
- Address rule: imem_addr = BASE_ADDR + 4×word_index, using 32-bit arithmetic. word_index is 10 bits wide, enough to reach MAX_WORDS.
- Reset values:
  - State = IDLE.
  - imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0.
  - cpu_hold=1, done=0, err=0.
  - Sum = 0, indices = 0.
- rst asserted mid-frame aborts the frame immediately and returns to the reset values. A partially assembled word is never written.

## Timing

- rx_valid may be asserted on consecutive cycles; one byte is consumed per cycle with no stall.
- Write latency: imem_we, imem_addr and imem_wdata are registered. They are valid for exactly one cycle, the cycle after the edge that accepts the word's 4th byte.
- imem_addr and imem_wdata hold their values after imem_we deasserts.
- Status latency: done and err assert, and cpu_hold drops, one cycle after the edge that accepts the final byte (CSUM, or the last data byte when checksum is compiled out).
- For LEN=0 with checksum compiled out, DONE is entered on the edge that accepts LEN_HI.
- rx_valid=0 freezes all state. There is no timeout.

## Configuration

- BOOT_CHECKSUM_EN defined: the CSUM state and the 8-bit sum logic are present, and the frame carries a trailing checksum byte.
- BOOT_CHECKSUM_EN undefined: there is no checksum byte, and the sum register and CSUM state are removed. The last data word goes straight to DONE. err can then be raised only by LEN > MAX_WORDS.

## Test plan

- Load with checksum: stream A5 02 00 13 00 00 00 93 00 10 00 B6.
  - Required: writes 0x00000013 @0x0 and 0x00100093 @0x4.
  - done=1, cpu_hold=0, err=0.
- Bad checksum: same frame with CSUM=00.
  - Required: both writes occur, then err=1 with cpu_hold=1.
  - Then a valid frame beginning with A5 gives done=1.
- Oversize: A5 01 02 (LEN=513).
  - Required: err=1 with no imem_we pulse.
  - Subsequent non-A5 bytes are ignored.
- Framing: bytes 00 FF 13 before A5 are ignored. A5 00 00 00 gives done=1 with zero writes.
- Back-to-back bytes every cycle with LEN=512.
  - Required: 512 writes, last address 0x7FC, with each imem_we one cycle long.
  - A second A5 after done produces no writes.
- Reset mid-frame: assert rst after the 2nd data byte.
  - Required: all outputs at reset values immediately, no write issued.
  - A fresh frame then loads correctly.

Source files
------------

// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//   Loads the instruction memory from a UART byte stream before the core runs.
//   Frame: HEADER, LEN_LO, LEN_HI, LEN x 4 data bytes (LSB first), [CSUM].
//   The core is held in reset (cpu_hold=1) until a complete, valid image lands.
//
//   Optional feature macro: BOOT_CHECKSUM_EN
//     defined   -> trailing 8-bit additive checksum byte is checked
//     undefined -> no checksum byte; the last data word goes straight to DONE
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   rx_valid   in   one-cycle strobe, rx_data holds a received byte
//   rx_data    in   [7:0] received byte
//   imem_we    out  instruction-memory write enable, one-cycle pulse
//   imem_addr  out  [31:0] word-aligned write byte address (holds after the pulse)
//   imem_wdata out  [31:0] write data (holds after the pulse)
//   cpu_hold   out  core held in reset while high
//   done       out  image loaded; sticky until rst
//   err        out  frame rejected; sticky until the next HEADER
module uart_boot_loader #(
  parameter int          MAX_WORDS = 512,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;
`ifdef BOOT_CHECKSUM_EN
  localparam logic [2:0] S_CSUM   = 3'd4;
  // State entered once the payload is complete (or LEN==0).
  localparam logic [2:0] S_END    = S_CSUM;
`else
  localparam logic [2:0] S_END    = S_DONE;
`endif

  logic [2:0]  state;
  logic [15:0] len;
  logic [9:0]  word_idx;
  logic [1:0]  byte_idx;
  logic [31:0] word_sr;
  logic [31:0] word_nxt;
  logic [15:0] len_full;
  logic        last_word;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  sum;
`endif

  // Word with the incoming byte dropped into its lane; on the 4th byte this
  // is the complete word, so the write never waits on the register update.
  always_comb begin
    word_nxt = word_sr;
    word_nxt[byte_idx*8 +: 8] = rx_data;
  end

  assign len_full  = {rx_data, len[7:0]};
  assign last_word = ({6'd0, word_idx} == (len - 16'd1));

  // Status follows the registered state, so it changes one cycle after the
  // edge that accepts the deciding byte.
  assign done     = (state == S_DONE);
  assign err      = (state == S_ERR);
  assign cpu_hold = (state != S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      len        <= 16'd0;
      word_idx   <= 10'd0;
      byte_idx   <= 2'd0;
      word_sr    <= 32'd0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (rx_valid) begin
        case (state)
          S_IDLE: if (rx_data == HEADER) state <= S_LEN_LO;
          S_LEN_LO: begin
            len[7:0] <= rx_data;
            state    <= S_LEN_HI;
          end
          S_LEN_HI: begin
            len[15:8] <= rx_data;
            word_idx  <= 10'd0;
            byte_idx  <= 2'd0;
            word_sr   <= 32'd0;
            if (len_full > 16'(MAX_WORDS)) state <= S_ERR;
            else if (len_full == 16'd0)    state <= S_END;
            else                           state <= S_DATA;
          end
          S_DATA: begin
            word_sr  <= word_nxt;
            byte_idx <= byte_idx + 2'd1;
`ifdef BOOT_CHECKSUM_EN
            sum      <= sum + rx_data;
`endif
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= BASE_ADDR + {20'd0, word_idx, 2'b00};
              imem_wdata <= word_nxt;
              word_idx   <= word_idx + 10'd1;
              if (last_word) state <= S_END;
            end
          end
`ifdef BOOT_CHECKSUM_EN
          S_CSUM: state <= (rx_data == sum) ? S_DONE : S_ERR;
`endif
          S_DONE: ;  // only rst re-arms
          S_ERR: begin
            if (rx_data == HEADER) begin
              state    <= S_LEN_LO;
              word_idx <= 10'd0;
`ifdef BOOT_CHECKSUM_EN
              sum      <= 8'd0;
`endif
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader. Frames are built from the
// protocol rules (byte queues, plain sums); expected writes are the payload
// words at BASE + 4*i. Follows BOOT_CHECKSUM_EN the same way as the design.
module tb_uart_boot_loader;

`ifdef BOOT_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;

  uart_boot_loader dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] wq[$];     // observed writes {addr, data}
  logic [7:0]  frm[$];    // frame under test
  logic [31:0] exp_w[$];  // expected write data, word i at address 4*i
  logic        prev_we = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: capture every pulse and require it to last one cycle.
  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      chk("we_one_cycle", {31'd0, prev_we}, 32'd0);
      wq.push_back({imem_addr, imem_wdata});
    end
    prev_we = imem_we;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One byte per call; rx_data carries noise whenever rx_valid is low.
  task automatic send(input logic [7:0] b, input bit gaps);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (gaps) idle($urandom_range(0, 2));
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  // Model: random payload of len words; returns whether the frame must fail.
  task automatic build(input int len, input bit bad, output bit fail);
    logic [31:0] w;
    logic [7:0]  s;
    logic [15:0] l;
    l = 16'(len);
    s = 8'd0;
    frm.delete();
    exp_w.delete();
    frm.push_back(8'hA5);
    frm.push_back(l[7:0]);
    frm.push_back(l[15:8]);
    fail = (len > 512);
    if (len <= 512) begin
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        exp_w.push_back(w);
        for (int b = 0; b < 4; b++) begin
          frm.push_back(w[8*b +: 8]);
          s = s + w[8*b +: 8];
        end
      end
      if (CSUM_EN) begin
        frm.push_back(bad ? (s ^ 8'($urandom_range(1, 255))) : s);
        fail = bad;
      end
    end
  endtask

  // Send frm, check status timing around the last byte, then the writes.
  task automatic run(input string tag, input bit gaps, input bit fail);
    wq.delete();
    for (int i = 0; i < frm.size() - 1; i++) send(frm[i], gaps);
    chk({tag, "_pre_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_pre_err"},  {31'd0, err},  32'd0);
    send(frm[frm.size() - 1], 1'b0);
    chk({tag, "_done"}, {31'd0, done},     {31'd0, !fail});
    chk({tag, "_err"},  {31'd0, err},      {31'd0, fail});
    chk({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, fail});
    @(negedge clk);
    chk({tag, "_nwrites"}, 32'(wq.size()), 32'(exp_w.size()));
    for (int i = 0; i < wq.size() && i < exp_w.size(); i++) begin
      chk({tag, "_addr"}, wq[i][63:32], 32'(4 * i));
      chk({tag, "_data"}, wq[i][31:0],  exp_w[i]);
    end
    #1;
  endtask

  bit fail;

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'd0;
    #1;
    chk("rst_we",    {31'd0, imem_we},  32'd0);
    chk("rst_addr",  imem_addr,         32'd0);
    chk("rst_wdata", imem_wdata,        32'd0);
    chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("rst_done",  {31'd0, done},     32'd0);
    chk("rst_err",   {31'd0, err},      32'd0);
    do_reset();

    // Reference frame: two RV32I words, checksum 0xB6.
    frm = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    if (CSUM_EN) frm.push_back(8'hB6);
    exp_w = {32'h0000_0013, 32'h0010_0093};
    run("load", 1'b0, 1'b0);

    // Same frame with a wrong checksum, then recovery with a fresh frame.
    if (CSUM_EN) begin
      do_reset();
      frm[frm.size() - 1] = 8'h00;
      run("badcsum", 1'b0, 1'b1);
      build(3, 1'b0, fail);
      run("recover", 1'b1, fail);
    end

    // Oversize length: error, no write, junk ignored, header recovers.
    do_reset();
    build(513, 1'b0, fail);
    run("oversize", 1'b0, fail);
    wq.delete();
    send(8'h00, 1'b0);
    send(8'h11, 1'b1);
    chk("ovs_err_sticky", {31'd0, err}, 32'd1);
    chk("ovs_no_write",   32'(wq.size()), 32'd0);
    build(2, 1'b0, fail);
    run("ovs_recover", 1'b0, fail);

    // Leading junk ignored, empty image loads with zero writes.
    do_reset();
    send(8'h00, 1'b0);
    send(8'hFF, 1'b0);
    send(8'h13, 1'b0);
    build(0, 1'b0, fail);
    run("empty", 1'b0, fail);

    // Randomized frames with idle gaps and (when present) corrupt checksums.
    for (int k = 0; k < 8; k++) begin
      if (done) do_reset();
      build($urandom_range(1, 6), CSUM_EN ? 1'($urandom_range(0, 1)) : 1'b0, fail);
      run("rand", 1'b1, fail);
    end

    // Full capacity, one byte every cycle; then a new frame must not write.
    do_reset();
    build(512, 1'b0, fail);
    run("full", 1'b0, fail);
    chk("full_last_addr", wq[wq.size() - 1][63:32], 32'h0000_07FC);
    wq.delete();
    build(2, 1'b0, fail);
    for (int i = 0; i < frm.size(); i++) send(frm[i], 1'b0);
    idle(1);
    chk("after_done_writes", 32'(wq.size()), 32'd0);
    chk("after_done_done",   {31'd0, done}, 32'd1);

    // Reset after the 2nd data byte: immediate reset values, nothing written.
    do_reset();
    build(3, 1'b0, fail);
    wq.delete();
    for (int i = 0; i < 5; i++) send(frm[i], 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_we",    {31'd0, imem_we},  32'd0);
    chk("mid_addr",  imem_addr,         32'd0);
    chk("mid_wdata", imem_wdata,        32'd0);
    chk("mid_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("mid_done",  {31'd0, done},     32'd0);
    chk("mid_err",   {31'd0, err},      32'd0);
    idle(2);
    rst = 1'b0;
    chk("mid_no_write", 32'(wq.size()), 32'd0);
    build(4, 1'b0, fail);
    run("after_rst", 1'b1, fail);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
